// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the parametrised 1rw1r SRAM.
package sram_pkg;

  // Result returned by a port-1 read that hits a port-0 write in the same cycle.
  typedef enum logic {
    WRITE_FIRST = 1'b0,  // read sees the merged (post-write) word
    READ_FIRST  = 1'b1   // read sees the word as it was before the write
  } collision_mode_e;

  // Controller state; RESET and INIT both keep the ports closed.
  typedef enum logic [1:0] {
    RESET = 2'd0,
    INIT  = 2'd1,
    RUN   = 2'd2
  } sram_state_e;

  // Number of write-mask lanes for a word of dw bits split into gran-bit lanes.
  function automatic int calc_num_wmasks(input int dw, input int gran);
    return dw / gran;
  endfunction

  // Number of words addressed by aw address bits.
  function automatic int calc_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// One or two register stages carrying read data, a valid strobe and a
// collision strobe. Data only moves when its valid is set, so the output word
// holds its last value while valid is low.
module sram_read_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_coll,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_coll
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_coll;

  // First stage: capture the array read on the request edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_coll  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_coll  <= in_valid & in_coll;
      if (in_valid) begin
        s1_data <= in_data;
      end
    end
  end

  if (LATENCY == 2) begin : g_two_stage
    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;
    logic             s2_coll;

    // Second stage: output register for the two-cycle configuration.
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
        s2_coll  <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        s2_coll  <= s1_valid & s1_coll;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_coll  = s2_coll;
  end else begin : g_one_stage
    assign out_valid = s1_valid;
    assign out_data  = s1_data;
    assign out_coll  = s1_coll;
  end

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised single-clock SRAM: port 0 reads or writes with a lane mask,
// port 1 only reads. After reset an optional sweep zeroes every word before the
// ports open.
//
// Request/strobe semantics: a port issues a request by holding its csb low
// across a rising edge; there is no back-pressure, so every request accepted
// in RUN is answered exactly READ_LATENCY edges later by a one-cycle doutN_valid
// strobe. Requests presented outside RUN are dropped silently.
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int              DATA_WIDTH     = 32,
  parameter int              ADDR_WIDTH     = 8,
  parameter int              WMASK_GRAN     = 8,
  parameter int              READ_LATENCY   = 1,
  parameter collision_mode_e COLLISION_MODE = WRITE_FIRST,
  parameter bit              INIT_ON_RESET  = 1'b1,
  localparam int             NUM_WMASKS     = calc_num_wmasks(DATA_WIDTH, WMASK_GRAN)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  output logic [1:0]            state_dbg,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision
);

  localparam int DEPTH = calc_depth(ADDR_WIDTH);

  if (!(READ_LATENCY == 1 || READ_LATENCY == 2)) begin : g_bad_latency
    $error("sram_1rw1r_param: READ_LATENCY must be 1 or 2");
  end
  if ((DATA_WIDTH % WMASK_GRAN) != 0) begin : g_bad_gran
    $error("sram_1rw1r_param: WMASK_GRAN must divide DATA_WIDTH");
  end

  sram_state_e           state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  run;
  logic                  init_wr;
  logic                  wr0;
  logic                  rd0;
  logic                  rd1;
  logic                  coll_hit;
  logic [DATA_WIDTH-1:0] lane_bits;
  logic [DATA_WIDTH-1:0] merged0;
  logic [DATA_WIDTH-1:0] rd0_word;
  logic [DATA_WIDTH-1:0] rd1_raw;
  logic [DATA_WIDTH-1:0] rd1_word;
  logic                  p0_coll;
  logic                  p1_coll;

  assign state_dbg = state;
  assign init_busy = (state != RUN);

  // Ports are live only in RUN and never on an edge where reset is sampled.
  assign run      = (state == RUN) && !rst;
  assign init_wr  = (state == INIT) && !rst;
  assign wr0      = run && !csb0 && !web0;
  assign rd0      = run && !csb0 && web0;
  assign rd1      = run && !csb1;
  assign coll_hit = wr0 && rd1 && (addr0 == addr1);

  // Expand the per-lane write mask into a per-bit mask.
  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      lane_bits[i*WMASK_GRAN +: WMASK_GRAN] = {WMASK_GRAN{wmask0[i]}};
    end
  end

  assign merged0  = (mem[addr0] & ~lane_bits) | (din0 & lane_bits);
  assign rd0_word = mem[addr0];
  assign rd1_raw  = mem[addr1];

  // Port-1 read word, substituting the merged write word on a write-first hit.
  always_comb begin
    rd1_word = rd1_raw;
    if (coll_hit && (COLLISION_MODE == WRITE_FIRST)) begin
      rd1_word = merged0;
    end
  end

  // Controller: RESET holds everything, INIT sweeps the array, RUN serves ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RESET;
      init_cnt <= '0;
    end else begin
      unique case (state)
        RESET: begin
          init_cnt <= '0;
          if (INIT_ON_RESET) begin
            state <= INIT;
          end else begin
            state <= RUN;
          end
        end
        INIT: begin
          init_cnt <= init_cnt + ADDR_WIDTH'(1);
          if (&init_cnt) begin
            state <= RUN;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= RESET;
        end
      endcase
    end
  end

  // Array write: the init sweep zeroes one word per cycle, otherwise port 0
  // updates only the lanes selected by its mask.
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[init_cnt] <= '0;
    end else if (wr0) begin
      mem[addr0] <= merged0;
    end
  end

  sram_read_pipe #(
    .WIDTH   (DATA_WIDTH),
    .LATENCY (READ_LATENCY)
  ) u_pipe0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd0),
    .in_data   (rd0_word),
    .in_coll   (1'b0),
    .out_valid (dout0_valid),
    .out_data  (dout0),
    .out_coll  (p0_coll)
  );

  sram_read_pipe #(
    .WIDTH   (DATA_WIDTH),
    .LATENCY (READ_LATENCY)
  ) u_pipe1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd1),
    .in_data   (rd1_word),
    .in_coll   (coll_hit),
    .out_valid (dout1_valid),
    .out_data  (dout1),
    .out_coll  (p1_coll)
  );

  // Port 0 has no collision source, so p0_coll is constant zero; merging it
  // keeps both pipe instances structurally identical.
  assign collision = p1_coll | p0_coll;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: three instances share one stimulus stream
// (write-first/latency 1, read-first/latency 2, and write-first without the
// init sweep) and are checked against an array-based reference model.
module tb_sram_1rw1r_param;
  import sram_pkg::*;

  localparam int DEPTH = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0;

  logic [31:0] wf_dout0, wf_dout1, rf_dout0, rf_dout1, ni_dout0, ni_dout1;
  logic        wf_v0, wf_v1, wf_coll, wf_busy;
  logic        rf_v0, rf_v1, rf_coll, rf_busy;
  logic        ni_v0, ni_v1, ni_coll, ni_busy;
  logic [1:0]  wf_state, rf_state, ni_state;

  sram_1rw1r_param #(.READ_LATENCY(1), .COLLISION_MODE(WRITE_FIRST), .INIT_ON_RESET(1'b1)) u_wf (
    .clk(clk), .rst(rst), .init_busy(wf_busy), .state_dbg(wf_state),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(wf_dout0), .dout0_valid(wf_v0), .csb1(csb1), .addr1(addr1),
    .dout1(wf_dout1), .dout1_valid(wf_v1), .collision(wf_coll));

  sram_1rw1r_param #(.READ_LATENCY(2), .COLLISION_MODE(READ_FIRST), .INIT_ON_RESET(1'b1)) u_rf (
    .clk(clk), .rst(rst), .init_busy(rf_busy), .state_dbg(rf_state),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(rf_dout0), .dout0_valid(rf_v0), .csb1(csb1), .addr1(addr1),
    .dout1(rf_dout1), .dout1_valid(rf_v1), .collision(rf_coll));

  sram_1rw1r_param #(.READ_LATENCY(1), .COLLISION_MODE(WRITE_FIRST), .INIT_ON_RESET(1'b0)) u_ni (
    .clk(clk), .rst(rst), .init_busy(ni_busy), .state_dbg(ni_state),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(ni_dout0), .dout0_valid(ni_v0), .csb1(csb1), .addr1(addr1),
    .dout1(ni_dout1), .dout1_valid(ni_v1), .collision(ni_coll));

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    logic        coll;
    int          due;
  } exp_t;

  // Index: 0 = wf port0, 1 = wf port1, 2 = rf port0, 3 = rf port1.
  exp_t        exp_q[4][$];
  int          lat[4] = '{1, 1, 2, 2};
  logic [31:0] last[4];
  logic [31:0] ref_mem[DEPTH];
  int          cyc = 0;
  int          rel_cyc = 0;
  bit          in_rst = 1'b1;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: applies the behaviour of one rising edge to ref_mem and
  // records the read results each instance owes, with the cycle they are due.
  task automatic model_edge();
    logic [31:0] pre1;
    bit          wr, rd0, rd1, hit;
    cyc++;
    if (rst) begin
      in_rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
        exp_q[i].delete();
        last[i] = '0;
      end
    end else if (in_rst) begin
      in_rst  = 1'b0;
      rel_cyc = cyc;
    end else if (cyc - rel_cyc <= DEPTH) begin
      ref_mem[cyc - rel_cyc - 1] = '0;
    end else begin
      wr   = !csb0 && !web0;
      rd0  = !csb0 && web0;
      rd1  = !csb1;
      hit  = wr && rd1 && (addr0 == addr1);
      pre1 = ref_mem[addr1];
      if (rd0) begin
        exp_q[0].push_back('{data: ref_mem[addr0], coll: 1'b0, due: cyc + lat[0] - 1});
        exp_q[2].push_back('{data: ref_mem[addr0], coll: 1'b0, due: cyc + lat[2] - 1});
      end
      if (wr) begin
        for (int l = 0; l < 4; l++) begin
          if (wmask0[l]) ref_mem[addr0][8*l +: 8] = din0[8*l +: 8];
        end
      end
      if (rd1) begin
        exp_q[1].push_back('{data: ref_mem[addr1], coll: hit, due: cyc + lat[1] - 1});
        exp_q[3].push_back('{data: pre1, coll: hit, due: cyc + lat[3] - 1});
      end
    end
  endtask

  task automatic check_port(input int idx, input logic v, input logic [31:0] d, input logic c);
    exp_t e;
    if (v) begin
      if (exp_q[idx].size() == 0) begin
        chk($sformatf("spurious_valid_%0d", idx), 32'd1, 32'd0);
      end else begin
        e = exp_q[idx].pop_front();
        chk($sformatf("data_%0d", idx), d, e.data);
        chk($sformatf("latency_%0d", idx), cyc, e.due);
        if (idx % 2 == 1) chk($sformatf("coll_%0d", idx), {31'd0, c}, {31'd0, e.coll});
        last[idx] = e.data;
      end
    end else begin
      if (exp_q[idx].size() > 0 && exp_q[idx][0].due <= cyc) begin
        chk($sformatf("valid_missing_%0d", idx), 32'd0, 32'd1);
        void'(exp_q[idx].pop_front());
      end
      chk($sformatf("hold_%0d", idx), d, last[idx]);
      if (idx % 2 == 1) chk($sformatf("coll_idle_%0d", idx), {31'd0, c}, 32'd0);
    end
  endtask

  task automatic check_all();
    logic exp_busy;
    exp_busy = in_rst || (cyc - rel_cyc < DEPTH);
    chk("busy_wf", {31'd0, wf_busy}, {31'd0, exp_busy});
    chk("busy_rf", {31'd0, rf_busy}, {31'd0, exp_busy});
    chk("busy_ni", {31'd0, ni_busy}, {31'd0, in_rst});
    check_port(0, wf_v0, wf_dout0, 1'b0);
    check_port(1, wf_v1, wf_dout1, wf_coll);
    check_port(2, rf_v0, rf_dout0, 1'b0);
    check_port(3, rf_v1, rf_dout1, rf_coll);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive_idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 8'h00; din0 = '0;
    csb1 = 1'b1; addr1 = 8'h00;
  endtask

  task automatic drive_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  task automatic drive_read0(input logic [7:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a; wmask0 = 4'h0;
  endtask

  task automatic drive_read1(input logic [7:0] a);
    csb1 = 1'b0; addr1 = a;
  endtask

  // Clocks until the init sweep finishes; n counts samples with init_busy high.
  task automatic wait_init(output int n);
    n = 0;
    do begin
      tick();
      if (wf_busy) n++;
    end while (wf_busy && n < 400);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          n;
    logic [31:0] seen[$];

    rst = 1'b1;
    drive_idle();
    repeat (3) tick();
    chk("reset_state", {30'd0, wf_state}, {30'd0, RESET});
    rst = 1'b0;
    wait_init(n);
    chk("init_len", n, 32'd256);

    // Last word of the sweep reads back zero.
    drive_read1(8'hFF);
    tick();
    drive_idle();
    chk("init_zero_ff", wf_dout1, 32'h0);
    chk("init_zero_ff_v", {31'd0, wf_v1}, 32'd1);
    tick();

    // Masked merge.
    drive_write(8'h10, 32'hDEADBEEF, 4'b1111); tick();
    drive_write(8'h10, 32'h11223344, 4'b0101); tick();
    drive_read0(8'h10); tick();
    drive_idle();
    chk("merge_wf", wf_dout0, 32'hDE22BE44);
    tick();
    chk("merge_rf", rf_dout0, 32'hDE22BE44);

    // Same-address collision.
    drive_write(8'h20, 32'h0, 4'b1111); tick();
    drive_write(8'h20, 32'hAAAA5555, 4'b0011);
    drive_read1(8'h20);
    tick();
    drive_idle();
    chk("coll_wf_data", wf_dout1, 32'h00005555);
    chk("coll_wf_flag", {31'd0, wf_coll}, 32'd1);
    tick();
    chk("coll_rf_data", rf_dout1, 32'h00000000);
    chk("coll_rf_flag", {31'd0, rf_coll}, 32'd1);

    // Read on the cycle after a write sees the new word on both ports.
    drive_write(8'h21, 32'h0BADCAFE, 4'b1111); tick();
    drive_read0(8'h21); drive_read1(8'h21); tick();
    drive_idle(); tick(); tick();

    // Back-to-back reads through the two-stage pipe.
    for (int i = 1; i <= 4; i++) begin
      drive_write(8'(i), 32'h11111111 * i, 4'b1111);
      tick();
    end
    for (int i = 1; i <= 4; i++) begin
      drive_read0(8'(i)); drive_read1(8'(i));
      tick();
      if (rf_v1) seen.push_back(rf_dout1);
    end
    drive_idle();
    repeat (2) begin
      tick();
      if (rf_v1) seen.push_back(rf_dout1);
    end
    chk("b2b_count", seen.size(), 32'd4);
    for (int i = 0; i < seen.size(); i++) begin
      chk($sformatf("b2b_order_%0d", i), seen[i], 32'h11111111 * (i + 1));
    end

    // Hold behaviour with both ports idle.
    drive_write(8'h30, 32'hCAFEF00D, 4'b1111); tick();
    drive_read0(8'h30); tick();
    drive_idle(); tick(); tick();
    chk("hold_wf", wf_dout0, 32'hCAFEF00D);
    chk("hold_wf_v", {31'd0, wf_v0}, 32'd0);
    chk("hold_rf", rf_dout0, 32'hCAFEF00D);

    // Reset part-way through the sweep; requests during init are dropped.
    drive_write(8'h00, 32'h5A5A5A5A, 4'b1111); tick();
    drive_write(8'hFF, 32'h5A5A5A5A, 4'b1111); tick();
    drive_idle();
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    drive_write(8'h05, 32'h12345678, 4'b1111);
    drive_read1(8'h05);
    repeat (129) tick();
    chk("mid_init_state", {30'd0, wf_state}, {30'd0, INIT});
    rst = 1'b1; tick();
    rst = 1'b0;
    wait_init(n);
    chk("reinit_len", n, 32'd256);
    drive_idle();
    drive_read0(8'h05); tick();
    drive_idle();
    chk("init_drop_wr", wf_dout0, 32'h0);
    drive_read0(8'h00); drive_read1(8'hFF); tick();
    drive_idle();
    chk("reinit_00", wf_dout0, 32'h0);
    chk("reinit_ff", wf_dout1, 32'h0);

    // Randomised traffic on a small address window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      csb0   = 1'($urandom_range(0, 1));
      web0   = 1'($urandom_range(0, 1));
      wmask0 = 4'($urandom_range(0, 15));
      addr0  = 8'($urandom_range(0, 7));
      din0   = $urandom;
      csb1   = 1'($urandom_range(0, 1));
      addr1  = 8'($urandom_range(0, 7));
      tick();
    end
    drive_idle();
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_%0d", i), exp_q[i].size(), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
